// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//   Round-robin arbiter sharing one FIFO write port among N valid/ready
//   producers. One producer is granted per cycle, combinationally from the
//   registered owner/burst state, req_valid and fifo_full. An owner may keep
//   the port for at most MAX_BURST consecutive beats while others wait; after
//   that the search rotates starting at owner+1, with the owner checked last.
//
// Parameters
//   DW         data width (matches the FIFO)
//   N          number of producers, 2..16
//   MAX_BURST  maximum consecutive grants to one owner, >= 1
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  [N]      producer i has a word
//   req_data   [N*DW]   producer i word at [i*DW +: DW]
//   req_ready  [N]      producer i word accepted this cycle (one-hot or zero)
//   fifo_din   [DW]     FIFO write data, 0 when nothing is granted
//   fifo_we             FIFO write enable
//   fifo_full           FIFO full; blocks every grant in the same cycle
//   grant_id   [clog2N] registered index of the current/last owner
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int DW        = 32,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*DW-1:0]      req_data,
    output logic [N-1:0]         req_ready,
    output logic [DW-1:0]        fifo_din,
    output logic                 fifo_we,
    input  logic                 fifo_full,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   burst_q, burst_d;

    logic [DW-1:0]   data_arr [N];
    logic            keep;      // current owner continues its burst
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;
    int              pos;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Grant decision
    always_comb begin
        keep    = (state_q == OWN) && req_valid[owner_q] &&
                  (burst_q < CW'(MAX_BURST));
        gnt_vld = 1'b0;
        gnt_idx = owner_q;
        cand    = owner_q;
        pos     = 0;
        if (keep) begin
            gnt_vld = 1'b1;
            gnt_idx = owner_q;
        end else begin
            // Walk the rotation backwards so the last hit is the first valid
            // index in the order owner+1, owner+2, ..., owner.
            for (int i = N; i >= 1; i--) begin
                pos = int'(owner_q) + i;
                if (pos >= N) pos = pos - N;
                cand = IW'(pos);
                if (req_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        // Full FIFO or reset aborts any grant in the same cycle.
        if (rst || fifo_full) begin
            gnt_vld = 1'b0;
        end
    end

    // Write port and handshake
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_ready[i] = gnt_vld && (gnt_idx == IW'(i));
        end
        fifo_we  = gnt_vld;
        fifo_din = gnt_vld ? data_arr[gnt_idx] : '0;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        if (!fifo_full) begin
            if (gnt_vld) begin
                state_d = OWN;
                if (keep) begin
                    burst_d = burst_q + CW'(1);
                end else begin
                    // New owner, or lone owner re-won after a full burst.
                    owner_d = gnt_idx;
                    burst_d = CW'(1);
                end
            end else begin
                // Nobody valid: owner is kept so the next search starts after it.
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= IW'(N - 1);   // first search after reset starts at 0
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    assign grant_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     fifo_din;
    logic              fifo_we;
    logic              fifo_full;
    logic [1:0]        grant_id;

    always #5 clk = ~clk;

    fifo_wr_arb #(.DW(DW), .N(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_din  (fifo_din),
        .fifo_we   (fifo_we),
        .fifo_full (fifo_full),
        .grant_id  (grant_id)
    );

    // Expected write per cycle; id -1 means no write that cycle.
    typedef struct {
        int          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   k[N];        // stimulus: next word index per producer
    int   ek[N];       // model: next expected word index per producer
    int   checks = 0;
    int   passes = 0;
    int   last_own;    // model of the registered owner

    task automatic push_w(input int id);
        exp_t e;
        e.id   = id;
        e.data = DW'(id * 256 + ek[id]);
        sb.push_back(e);
        ek[id]++;
    endtask

    task automatic push_b();
        exp_t e;
        e.id   = -1;
        e.data = '0;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge; outputs settle by +1.
    task automatic step(input logic [N-1:0] m, input logic f, input logic r);
        @(negedge clk);
        rst       = r;
        fifo_full = f;
        req_valid = m;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i * 256 + k[i]);
        #1;
    endtask

    // A producer whose ready is seen moves to its next word after the edge.
    task automatic advance();
        for (int i = 0; i < N; i++) if (req_ready[i]) k[i]++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            k[i]  = 0;
            ek[i] = 0;
        end
        sb.delete();
        last_own = N - 1;
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        clear_model();
    endtask

    task automatic test_reset();
        exp_t e;
        logic [N-1:0] er;
        logic r;
        clear_model();
        for (int c = 0; c < 3; c++) push_b();
        push_w(0);
        push_w(0);
        for (int c = 0; c < 5; c++) begin
            r = (c < 3);
            step('1, 1'b0, r);
            e  = sb.pop_front();
            er = (e.id < 0) ? '0 : N'(1 << e.id);
            checks++; if (fifo_we !== (e.id >= 0)) $display("FAIL reset c%0d fifo_we got %b want %b", c, fifo_we, e.id >= 0); else passes++;
            checks++; if (req_ready !== er) $display("FAIL reset c%0d req_ready got %b want %b", c, req_ready, er); else passes++;
            checks++; if (fifo_din !== e.data) $display("FAIL reset c%0d fifo_din got %h want %h", c, fifo_din, e.data); else passes++;
            checks++; if (grant_id !== 2'(last_own)) $display("FAIL reset c%0d grant_id got %0d want %0d", c, grant_id, last_own); else passes++;
            if (r) last_own = N - 1; else if (e.id >= 0) last_own = e.id;
            advance();
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        logic [N-1:0] er;
        do_reset();
        for (int c = 0; c < 20; c++) push_w((c / MB) % N);
        for (int c = 0; c < 20; c++) begin
            step('1, 1'b0, 1'b0);
            e  = sb.pop_front();
            er = (e.id < 0) ? '0 : N'(1 << e.id);
            checks++; if (fifo_we !== (e.id >= 0)) $display("FAIL rotation c%0d fifo_we got %b want %b", c, fifo_we, e.id >= 0); else passes++;
            checks++; if (req_ready !== er) $display("FAIL rotation c%0d req_ready got %b want %b", c, req_ready, er); else passes++;
            checks++; if (fifo_din !== e.data) $display("FAIL rotation c%0d fifo_din got %h want %h", c, fifo_din, e.data); else passes++;
            checks++; if (grant_id !== 2'(last_own)) $display("FAIL rotation c%0d grant_id got %0d want %0d", c, grant_id, last_own); else passes++;
            if (e.id >= 0) last_own = e.id;
            advance();
        end
    endtask

    task automatic test_lone();
        exp_t e;
        logic [N-1:0] m;
        logic [N-1:0] er;
        do_reset();
        for (int c = 0; c < 10; c++) push_w(2);
        push_b();
        for (int c = 0; c < 11; c++) begin
            m = (c < 10) ? 4'b0100 : 4'b0000;
            step(m, 1'b0, 1'b0);
            e  = sb.pop_front();
            er = (e.id < 0) ? '0 : N'(1 << e.id);
            checks++; if (fifo_we !== (e.id >= 0)) $display("FAIL lone c%0d fifo_we got %b want %b", c, fifo_we, e.id >= 0); else passes++;
            checks++; if (req_ready !== er) $display("FAIL lone c%0d req_ready got %b want %b", c, req_ready, er); else passes++;
            checks++; if (fifo_din !== e.data) $display("FAIL lone c%0d fifo_din got %h want %h", c, fifo_din, e.data); else passes++;
            checks++; if (grant_id !== 2'(last_own)) $display("FAIL lone c%0d grant_id got %0d want %0d", c, grant_id, last_own); else passes++;
            if (e.id >= 0) last_own = e.id;
            advance();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [N-1:0] er;
        logic f;
        do_reset();
        for (int c = 0; c < 4; c++) push_w(0);
        push_w(1);
        for (int c = 0; c < 3; c++) push_b();
        for (int c = 0; c < 3; c++) push_w(1);
        for (int c = 0; c < 4; c++) push_w(2);
        for (int c = 0; c < 15; c++) begin
            f = (c >= 5 && c <= 7);
            step('1, f, 1'b0);
            e  = sb.pop_front();
            er = (e.id < 0) ? '0 : N'(1 << e.id);
            checks++; if (fifo_we !== (e.id >= 0)) $display("FAIL backpressure c%0d fifo_we got %b want %b", c, fifo_we, e.id >= 0); else passes++;
            checks++; if (req_ready !== er) $display("FAIL backpressure c%0d req_ready got %b want %b", c, req_ready, er); else passes++;
            checks++; if (fifo_din !== e.data) $display("FAIL backpressure c%0d fifo_din got %h want %h", c, fifo_din, e.data); else passes++;
            checks++; if (grant_id !== 2'(last_own)) $display("FAIL backpressure c%0d grant_id got %0d want %0d", c, grant_id, last_own); else passes++;
            if (e.id >= 0) last_own = e.id;
            advance();
        end
    endtask

    task automatic test_early_release();
        exp_t e;
        logic [N-1:0] m;
        logic [N-1:0] er;
        do_reset();
        push_w(0); push_w(0);
        for (int c = 0; c < 4; c++) push_w(3);
        for (int c = 0; c < 4; c++) push_w(0);
        push_w(3);
        for (int c = 0; c < 11; c++) begin
            m = (c < 2) ? 4'b0001 : (c == 2) ? 4'b1000 : 4'b1001;
            step(m, 1'b0, 1'b0);
            e  = sb.pop_front();
            er = (e.id < 0) ? '0 : N'(1 << e.id);
            checks++; if (fifo_we !== (e.id >= 0)) $display("FAIL early_release c%0d fifo_we got %b want %b", c, fifo_we, e.id >= 0); else passes++;
            checks++; if (req_ready !== er) $display("FAIL early_release c%0d req_ready got %b want %b", c, req_ready, er); else passes++;
            checks++; if (fifo_din !== e.data) $display("FAIL early_release c%0d fifo_din got %h want %h", c, fifo_din, e.data); else passes++;
            checks++; if (grant_id !== 2'(last_own)) $display("FAIL early_release c%0d grant_id got %0d want %0d", c, grant_id, last_own); else passes++;
            if (e.id >= 0) last_own = e.id;
            advance();
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic [N-1:0] m;
        logic [N-1:0] er;
        logic r;
        do_reset();
        push_w(3); push_w(3);
        push_b();
        for (int c = 0; c < 4; c++) push_w(0);
        push_w(1);
        for (int c = 0; c < 8; c++) begin
            m = (c < 2) ? 4'b1000 : 4'b1111;
            r = (c == 2);
            step(m, 1'b0, r);
            e  = sb.pop_front();
            er = (e.id < 0) ? '0 : N'(1 << e.id);
            checks++; if (fifo_we !== (e.id >= 0)) $display("FAIL mid_reset c%0d fifo_we got %b want %b", c, fifo_we, e.id >= 0); else passes++;
            checks++; if (req_ready !== er) $display("FAIL mid_reset c%0d req_ready got %b want %b", c, req_ready, er); else passes++;
            checks++; if (fifo_din !== e.data) $display("FAIL mid_reset c%0d fifo_din got %h want %h", c, fifo_din, e.data); else passes++;
            checks++; if (grant_id !== 2'(last_own)) $display("FAIL mid_reset c%0d grant_id got %0d want %0d", c, grant_id, last_own); else passes++;
            if (r) last_own = N - 1; else if (e.id >= 0) last_own = e.id;
            advance();
        end
    endtask

    initial begin
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        test_reset();
        test_rotation();
        test_lone();
        test_backpressure();
        test_early_release();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
